util_shift_unloader: RTL and testbench
======================================

UTIL_SHIFT_UNLOADER -- requirements
Module: util_shift_unloader

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 16: bits per lane element.
REQ-002 SHALL have parameter ELEMENT_COUNT, default 4: lanes per row; legal range 2..32.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output row buffer depth; power of 2, at least 2.
REQ-004 SHALL derive localparam FULL_WIDTH = ELEMENT_WIDTH*ELEMENT_COUNT.
REQ-005 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all in-flight and buffered rows.
REQ-008 SHALL have port in_valid, input, 1 bit: qualifies lane 0 of a new row in the current cycle.
REQ-009 SHALL have port packed_in, input, FULL_WIDTH: skewed lanes; lane k at bits [k*ELEMENT_WIDTH +: ELEMENT_WIDTH].
REQ-010 SHALL have port out_valid, output, 1 bit: an aligned row is available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the row.
REQ-012 SHALL have port packed_out, output, FULL_WIDTH: aligned row; lane k carries input lane k.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, a completed row was dropped.

Function
REQ-014 SHALL treat input as skewed: lane k of the row started by in_valid at cycle t is sampled at cycle t+k; in_valid is not repeated for lanes 1..ELEMENT_COUNT-1.
REQ-015 SHALL delay lane k by ELEMENT_COUNT-1-k registers, so all lanes of one row align at cycle t+ELEMENT_COUNT-1.
REQ-016 SHALL delay in_valid through an ELEMENT_COUNT-1 stage valid pipeline; its output is the row-complete strobe.
REQ-017 SHALL push the aligned row into the FIFO on row-complete; with the FIFO empty, out_valid rises at t+ELEMENT_COUNT (latency ELEMENT_COUNT cycles).
REQ-018 SHALL accept back-to-back rows, one new in_valid per cycle, with sustained throughput of 1 row per cycle while out_ready=1.
REQ-019 SHALL pop a row on out_valid && out_ready; the FIFO is show-ahead, so packed_out is valid whenever out_valid=1 and holds stable until popped.
REQ-020 SHALL allow push and pop in the same cycle when the FIFO is full; that cycle is not an overflow.
REQ-021 SHALL drop the completed row when the FIFO is full and there is no pop in that cycle; FIFO contents are unchanged and overflow is set to 1.
REQ-022 SHALL return out_valid=0 when the FIFO is empty; a push into an empty FIFO is visible on the next cycle, with no combinational in-to-out path.
REQ-023 SHALL, on flush=1, clear the valid pipeline and the FIFO pointers so out_valid=0 next cycle; overflow is retained; a coincident in_valid is discarded.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH, using an extra bit to distinguish full from empty.

Reset
REQ-025 SHALL, with rst_n=0 at a clk edge, clear the valid pipeline, FIFO pointers and overflow, giving out_valid=0, overflow=0 and packed_out=0.
REQ-026 SHALL not require reset for lane data delay registers or FIFO storage; packed_out SHALL still read 0 while empty after reset.
REQ-027 SHALL, on reset mid-operation, abandon all partially skewed rows; lanes arriving after reset release produce no output.

Configuration
REQ-028 SHALL, with macro UTIL_SHIFT_UNLOADER_OVF_CNT_EN defined, add output port ovf_count[15:0]: count of dropped rows, saturating at 16'hFFFF, cleared by reset only.
REQ-029 SHALL, without UTIL_SHIFT_UNLOADER_OVF_CNT_EN, omit the ovf_count port and counter; all other behaviour is identical.

Structure
REQ-030 SHALL place the clog2 helper function and the FIFO pointer width computation in shared package mm_util_pkg; no module-specific typedefs go in it.
REQ-031 SHALL implement the FIFO as sub-module util_sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty), instantiated once; the deskew pipeline stays in the top module.

Verification
REQ-032 SHALL cover single row, COUNT=4, W=16, out_ready=1: in_valid at cycle 0 with lane k = 16'h0A0k sent at cycle k -> out_valid at cycle 4, packed_out = {16'h0A03,16'h0A02,16'h0A01,16'h0A00}.
REQ-033 SHALL cover 8 back-to-back rows with out_ready=1 -> 8 consecutive out_valid cycles, rows in order, overflow=0.
REQ-034 SHALL cover out_ready=0 with 6 rows, FIFO_DEPTH=4 -> 4 rows buffered, rows 5-6 dropped, overflow=1, ovf_count=2 (macro on); then out_ready=1 -> exactly rows 1-4 output.
REQ-035 SHALL cover full FIFO with out_ready=1 and a new row completing in the same cycle -> pop and push both happen, no overflow, order preserved.
REQ-036 SHALL cover flush asserted 2 cycles after in_valid with 2 rows buffered -> out_valid=0 next cycle, no further output, overflow unchanged.
REQ-037 SHALL cover rst_n=0 for 1 cycle mid-row -> out_valid=0, overflow=0 and packed_out=0 after reset; the trailing lanes produce no row.

Source files
------------

// File: rtl/mm_util_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mm_util_pkg : shared sizing helpers for utility blocks              |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package mm_util_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // One bit beyond the address lets full and empty be told apart.
    function automatic int fifo_ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage : mm_util_pkg
`default_nettype wire

// File: rtl/util_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | util_sync_fifo : show-ahead synchronous FIFO, flush clears pointers |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module util_sync_fifo
    import mm_util_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_PW = fifo_ptr_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                   (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);

    // A full FIFO still takes a push when the same cycle frees a slot.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

    // Storage is never reset, so mask it while nothing is held.
    assign dout = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule : util_sync_fifo
`default_nettype wire

// File: rtl/util_shift_unloader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | util_shift_unloader : deskews lane-staggered rows into a row FIFO   |
// | Option  : UTIL_SHIFT_UNLOADER_OVF_CNT_EN adds ovf_count[15:0]       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module util_shift_unloader
    import mm_util_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 16,
    parameter int ELEMENT_COUNT = 4,
    parameter int FIFO_DEPTH    = 4,
    localparam int FULL_WIDTH   = ELEMENT_WIDTH * ELEMENT_COUNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [FULL_WIDTH-1:0] packed_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FULL_WIDTH-1:0] packed_out,
`ifdef UTIL_SHIFT_UNLOADER_OVF_CNT_EN
    output logic [15:0]           ovf_count,
`endif
    output logic                  overflow
);

    localparam int c_VSTG = ELEMENT_COUNT - 1;

    logic [FULL_WIDTH-1:0] w_aligned;
    logic [c_VSTG-1:0]     r_vpipe;
    logic                  w_row_done;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic                  r_overflow;

    // Lane k arrives k cycles late; pad it so every lane lands together.
    for (genvar k = 0; k < ELEMENT_COUNT; k++) begin : g_lane
        localparam int c_DLY = ELEMENT_COUNT - 1 - k;
        if (c_DLY == 0) begin : g_pass
            assign w_aligned[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
                packed_in[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end else begin : g_dly
            logic [ELEMENT_WIDTH-1:0] r_sr [c_DLY];
            always_ff @(posedge clk) begin
                r_sr[0] <= packed_in[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                for (int i = 1; i < c_DLY; i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_aligned[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = r_sr[c_DLY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= in_valid;
            for (int i = 1; i < c_VSTG; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    assign w_row_done = r_vpipe[c_VSTG-1];
    assign w_push     = w_row_done && !flush;
    assign w_pop      = out_valid && out_ready;
    assign w_drop     = w_push && w_full && !w_pop;

    util_sync_fifo #(
        .WIDTH (FULL_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_aligned),
        .dout  (packed_out),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid = !w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

`ifdef UTIL_SHIFT_UNLOADER_OVF_CNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

endmodule : util_shift_unloader
`default_nettype wire

// File: tb/tb_util_shift_unloader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_util_shift_unloader : directed bench with row-queue model        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_util_shift_unloader;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int FW = W * C;
    localparam int HN = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] packed_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] packed_out;
    logic          overflow;
`ifdef UTIL_SHIFT_UNLOADER_OVF_CNT_EN
    logic [15:0]   ovf_count;
`endif

    util_shift_unloader #(
        .ELEMENT_WIDTH (W),
        .ELEMENT_COUNT (C),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .packed_in  (packed_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .packed_out (packed_out),
`ifdef UTIL_SHIFT_UNLOADER_OVF_CNT_EN
        .ovf_count  (ovf_count),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every cycle's pins are logged; a row started at s completes
    // at s+C-1 unless a reset or flush landed anywhere in [s, s+C-1].
    logic [FW-1:0] hist_d [HN];
    bit            hist_v [HN];
    logic [FW-1:0] mq [$];
    bit            m_started = 0;
    bit            m_ovf = 0;
    int            m_cnt = 0;
    int            m_n = 0;
    int            m_last_kill = -1;

    task automatic model_step();
        int s;
        bit pop;
        logic [FW-1:0] row;
        hist_d[m_n] = packed_in;
        hist_v[m_n] = (in_valid === 1'b1);
        if (!rst_n) begin
            m_started   = 1;
            m_last_kill = m_n;
            mq.delete();
            m_ovf = 0;
            m_cnt = 0;
        end else if (flush) begin
            m_last_kill = m_n;
            mq.delete();
        end else begin
            pop = (mq.size() > 0) && out_ready;
            s = m_n - (C - 1);
            if (pop) void'(mq.pop_front());
            if (s >= 0 && hist_v[s] && m_last_kill < s) begin
                for (int k = 0; k < C; k++)
                    row[k*W +: W] = hist_d[s+k][k*W +: W];
                if (mq.size() < D) begin
                    mq.push_back(row);
                end else begin
                    m_ovf = 1;
                    if (m_cnt < 16'hFFFF) m_cnt++;
                end
            end
        end
        m_n++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_started) begin
            check("out_valid", FW'(out_valid), FW'(mq.size() > 0));
            check("packed_out", packed_out, (mq.size() > 0) ? mq[0] : '0);
            check("overflow", FW'(overflow), FW'(m_ovf));
`ifdef UTIL_SHIFT_UNLOADER_OVF_CNT_EN
            check("ovf_count", FW'(ovf_count), FW'(m_cnt));
`endif
        end
    end

    // Stimulus: sched[c] holds the id of a row started at cycle c, or -1.
    int sched [HN];
    int cyc = 0;

    task automatic step();
        int r;
        in_valid = (sched[cyc] >= 0);
        for (int k = 0; k < C; k++) begin
            r = (cyc - k >= 0) ? sched[cyc-k] : -1;
            packed_in[k*W +: W] = (r >= 0) ? {8'(r), 8'(k)} : W'($urandom);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic add_rows(input int first_id, input int n);
        for (int i = 0; i < n; i++) sched[cyc+i] = first_id + i;
    endtask

    initial begin
        for (int i = 0; i < HN; i++) sched[i] = -1;

        // Reset
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
        check("rst_out_valid", FW'(out_valid), '0);
        check("rst_overflow", FW'(overflow), '0);
        check("rst_packed_out", packed_out, '0);
        steps(2);

        // Single row: latency C, lanes aligned
        out_ready = 1'b1;
        add_rows(8'h0A, 1);
        steps(4);
        check("single_valid", FW'(out_valid), FW'(1));
        check("single_row", packed_out, 64'h0A03_0A02_0A01_0A00);
        steps(3);

        // Eight back-to-back rows at full throughput
        add_rows(8'h10, 8);
        steps(4);
        check("b2b_first", packed_out, 64'h1003_1002_1001_1000);
        steps(7);
        check("b2b_last", packed_out, 64'h1703_1702_1701_1700);
        steps(3);
        check("b2b_no_ovf", FW'(overflow), '0);

        // Six rows into a stalled depth-4 FIFO: two dropped
        out_ready = 1'b0;
        add_rows(8'h20, 6);
        steps(10);
        check("stall_ovf", FW'(overflow), FW'(1));
        check("stall_head", packed_out, 64'h2003_2002_2001_2000);
`ifdef UTIL_SHIFT_UNLOADER_OVF_CNT_EN
        check("stall_ovf_count", FW'(ovf_count), FW'(2));
`endif
        out_ready = 1'b1;
        steps(3);
        check("stall_row4", packed_out, 64'h2303_2302_2301_2300);
        steps(3);
        check("stall_drained", FW'(out_valid), '0);

        // Flush with two rows buffered and a third in flight
        out_ready = 1'b0;
        add_rows(8'h30, 2);
        steps(5);
        add_rows(8'h38, 1);
        steps(2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", FW'(out_valid), '0);
        check("flush_ovf_kept", FW'(overflow), FW'(1));
        out_ready = 1'b1;
        steps(6);
        check("flush_no_out", FW'(out_valid), '0);

        // Reset mid-row: trailing lanes must not form a row
        add_rows(8'h40, 1);
        steps(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_valid", FW'(out_valid), '0);
        check("midrst_ovf", FW'(overflow), '0);
        check("midrst_data", packed_out, '0);
        steps(6);
        check("midrst_no_out", FW'(out_valid), '0);

        // Full FIFO, pop and push in the same cycle
        out_ready = 1'b0;
        add_rows(8'h50, 5);
        steps(7);
        out_ready = 1'b1;
        step();
        check("fullpp_no_ovf", FW'(overflow), '0);
        check("fullpp_head", packed_out, 64'h5103_5102_5101_5100);
        steps(3);
        check("fullpp_tail", packed_out, 64'h5403_5402_5401_5400);
        steps(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_util_shift_unloader
`default_nettype wire
